cnn_result_streamer: RTL and testbench

- Output-side reader for the time-multiplexed 4x4 cellular-array engine.
- Watches the engine's 16 parallel state outputs and counts completed 16-cycle sweeps via a sweep-complete pulse.
- Captures a frame snapshot when the iteration budget is reached or the array converges.
- Serialises the 16 snapshot words over a valid/ready stream to the downstream consumer.

---
 rtl/cnn_result_streamer.sv | 109 ++++++++++
 tb/tb_cnn_result_streamer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cnn_result_streamer.sv
// Output-side reader for the 4x4 cellular-array engine: waits for the iteration
// budget or convergence, snapshots the 16 cell states, then streams them out.
module cnn_result_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ITER_COUNT = 8,
  parameter int ITER_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         frame_tick,
  input  logic [16*DATA_WIDTH-1:0]     y_in,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [3:0]                   out_index,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         converged,
  output logic                         start_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]              state;
  logic [ITER_W-1:0]       iter_cnt;
  logic [ITER_W-1:0]       iter_next;
  logic                    prev_valid;
  logic [16*DATA_WIDTH-1:0] prev;
  logic [16*DATA_WIDTH-1:0] snapshot;
  logic [3:0]              idx;
  logic                    eq;
  logic                    hit;

  assign iter_next = iter_cnt + 1'b1;
  assign eq        = prev_valid && (y_in == prev);
  assign hit       = eq || (iter_next == ITER_W'(ITER_COUNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      iter_cnt   <= '0;
      prev_valid <= 1'b0;
      prev       <= '0;
      snapshot   <= '0;
      idx        <= '0;
      converged  <= 1'b0;
      start_err  <= 1'b0;
    end else begin
      if (start && (state == WAIT || state == SEND))
        start_err <= 1'b1;
      case (state)
        IDLE: begin
          // A frame_tick coinciding with start belongs to no collection.
          if (start) begin
            state      <= WAIT;
            iter_cnt   <= '0;
            prev_valid <= 1'b0;
            converged  <= 1'b0;
            start_err  <= 1'b0;
          end
        end
        WAIT: begin
          if (frame_tick) begin
            iter_cnt   <= iter_next;
            prev       <= y_in;
            prev_valid <= 1'b1;
            if (hit) begin
              snapshot  <= y_in;
              idx       <= '0;
              converged <= eq;
              state     <= SEND;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            idx <= idx + 4'd1;
            if (idx == 4'd15)
              state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_data  = '0;
    out_index = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_data  = snapshot[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
      out_index = idx;
      out_valid = 1'b1;
      out_last  = (idx == 4'd15);
    end
  end

  assign busy = (state == WAIT) || (state == SEND);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cnn_result_streamer.sv
// Directed bench for cnn_result_streamer; three instances cover budgets 3, 8 and 1.
module tb_cnn_result_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         frame_tick;
  logic [255:0] y_in;
  logic         out_ready;

  logic [15:0] o_data  [3];
  logic [3:0]  o_idx   [3];
  logic        o_valid [3];
  logic        o_last  [3];
  logic        o_busy  [3];
  logic        o_done  [3];
  logic        o_conv  [3];
  logic        o_serr  [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ready;
    logic [3:0]  exp_idx;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl [32];

  always #5 clk = ~clk;

  cnn_result_streamer #(.DATA_WIDTH(16), .ITER_COUNT(3), .ITER_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .y_in(y_in),
    .out_data(o_data[0]), .out_index(o_idx[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_last(o_last[0]), .busy(o_busy[0]),
    .done(o_done[0]), .converged(o_conv[0]), .start_err(o_serr[0]));

  cnn_result_streamer #(.DATA_WIDTH(16), .ITER_COUNT(8), .ITER_W(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .y_in(y_in),
    .out_data(o_data[1]), .out_index(o_idx[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_last(o_last[1]), .busy(o_busy[1]),
    .done(o_done[1]), .converged(o_conv[1]), .start_err(o_serr[1]));

  cnn_result_streamer #(.DATA_WIDTH(16), .ITER_COUNT(1), .ITER_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick), .y_in(y_in),
    .out_data(o_data[2]), .out_index(o_idx[2]), .out_valid(o_valid[2]),
    .out_ready(out_ready), .out_last(o_last[2]), .busy(o_busy[2]),
    .done(o_done[2]), .converged(o_conv[2]), .start_err(o_serr[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(input int base);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'(base + i);
    return v;
  endfunction

  task automatic sweep(input logic [255:0] y);
    repeat (4) step();
    frame_tick = 1'b1;
    y_in       = y;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_valid"}, 32'(o_valid[d]), 0);
    check({tag, "_busy"},  32'(o_busy[d]),  0);
    check({tag, "_done"},  32'(o_done[d]),  0);
    check({tag, "_data"},  32'(o_data[d]),  0);
    check({tag, "_index"}, 32'(o_idx[d]),   0);
    check({tag, "_conv"},  32'(o_conv[d]),  0);
    check({tag, "_serr"},  32'(o_serr[d]),  0);
  endtask

  logic [255:0] cy;
  int n;

  initial begin
    rst = 1'b0; start = 1'b0; frame_tick = 1'b0; y_in = '0; out_ready = 1'b1;

    // Budget capture (ITER_COUNT=3)
    do_reset();
    check_idle(0, "reset");
    start = 1'b1; step(); start = 1'b0;
    check("b_busy_after_start", 32'(o_busy[0]), 1);
    sweep(mk(16));
    check("b_tick1_no_valid", 32'(o_valid[0]), 0);
    sweep(mk(32));
    check("b_tick2_no_valid", 32'(o_valid[0]), 0);
    sweep(mk(48));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_valid%0d", i), 32'(o_valid[0]), 1);
      check($sformatf("b_data%0d", i),  32'(o_data[0]),  32'(48 + i));
      check($sformatf("b_idx%0d", i),   32'(o_idx[0]),   32'(i));
      check($sformatf("b_last%0d", i),  32'(o_last[0]),  32'(i == 15));
      check($sformatf("b_done%0d", i),  32'(o_done[0]),  0);
      step();
    end
    check("b_done", 32'(o_done[0]), 1);
    check("b_valid_in_done", 32'(o_valid[0]), 0);
    check("b_conv", 32'(o_conv[0]), 0);
    step();
    check("b_done_one_cycle", 32'(o_done[0]), 0);
    check("b_idle_busy", 32'(o_busy[0]), 0);

    // Convergence (ITER_COUNT=8)
    do_reset();
    cy = {16'hFF01, {15{16'h00FF}}};
    start = 1'b1; step(); start = 1'b0;
    sweep(cy);
    check("c_tick1_no_valid", 32'(o_valid[1]), 0);
    sweep(cy);
    check("c_valid", 32'(o_valid[1]), 1);
    check("c_conv", 32'(o_conv[1]), 1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("c_data%0d", i), 32'(o_data[1]), (i == 15) ? 32'hFF01 : 32'h00FF);
      check($sformatf("c_last%0d", i), 32'(o_last[1]), 32'(i == 15));
      step();
    end
    check("c_done", 32'(o_done[1]), 1);
    check("c_conv_sticky", 32'(o_conv[1]), 1);

    // Back-pressure with start pulsed mid-stream (ITER_COUNT=3)
    n = 0;
    for (int c = 0; c < 32; c++) begin
      tbl[c].ready    = (c % 4 == 0) || (c % 4 == 3);
      tbl[c].exp_idx  = 4'(n);
      tbl[c].exp_data = 16'(16'h8000 + n);
      if (tbl[c].ready) n++;
    end
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    sweep(mk(16'h7000));
    sweep(mk(16'h7800));
    sweep(mk(16'h8000));
    for (int c = 0; c < 32; c++) begin
      out_ready = tbl[c].ready;
      start     = (c == 5);
      check($sformatf("p_valid%0d", c), 32'(o_valid[0]), 1);
      check($sformatf("p_idx%0d", c),   32'(o_idx[0]),   32'(tbl[c].exp_idx));
      check($sformatf("p_data%0d", c),  32'(o_data[0]),  32'(tbl[c].exp_data));
      check($sformatf("p_last%0d", c),  32'(o_last[0]),  32'(tbl[c].exp_idx == 4'd15));
      check($sformatf("p_done%0d", c),  32'(o_done[0]),  0);
      step();
      start = 1'b0;
      if (c == 5) check("p_start_err_set", 32'(o_serr[0]), 1);
    end
    out_ready = 1'b1;
    check("p_done", 32'(o_done[0]), 1);
    check("p_start_err_held", 32'(o_serr[0]), 1);
    step();
    start = 1'b1; step(); start = 1'b0;
    check("p_start_err_cleared", 32'(o_serr[0]), 0);
    check("p_rearmed_busy", 32'(o_busy[0]), 1);

    // ITER_COUNT=1 with start and frame_tick coincident
    do_reset();
    start = 1'b1; frame_tick = 1'b1; y_in = mk(100);
    step();
    start = 1'b0; frame_tick = 1'b0;
    check("i_coincident_tick_ignored", 32'(o_valid[2]), 0);
    check("i_busy", 32'(o_busy[2]), 1);
    step();
    check("i_still_waiting", 32'(o_valid[2]), 0);
    sweep(mk(200));
    check("i_capture_valid", 32'(o_valid[2]), 1);
    check("i_capture_data", 32'(o_data[2]), 200);
    check("i_conv", 32'(o_conv[2]), 0);

    // Reset mid-stream (ITER_COUNT=3)
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    sweep(mk(16)); sweep(mk(32)); sweep(mk(48));
    for (int i = 0; i < 7; i++) begin
      check($sformatf("r_data%0d", i), 32'(o_data[0]), 32'(48 + i));
      step();
    end
    start = 1'b1; step(); start = 1'b0;
    check("r_serr_before_rst", 32'(o_serr[0]), 1);
    rst = 1'b1; step(); rst = 1'b0;
    check_idle(0, "r_after_rst");
    start = 1'b1; step(); start = 1'b0;
    sweep(mk(300));
    sweep(mk(400));
    check("r_two_ticks_no_capture", 32'(o_valid[0]), 0);
    check("r_two_ticks_busy", 32'(o_busy[0]), 1);
    sweep(mk(500));
    check("r_third_tick_capture", 32'(o_valid[0]), 1);
    check("r_third_tick_data", 32'(o_data[0]), 500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
